// File: rtl/wb_gpio_arbiter.sv
// wb_gpio_arbiter: round-robin Wishbone arbiter sharing the GPIO slave among NUM_MASTERS masters.
// Optional slave-ack watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_gpio_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [32*NUM_MASTERS-1:0] m_addr_i,
  input  logic [32*NUM_MASTERS-1:0] m_data_i,
  output logic [31:0]               m_data_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [31:0]               s_addr_o,
  output logic [31:0]               s_data_o,
  input  logic [31:0]               s_data_i,
  input  logic                      s_ack_i
);
  localparam int LW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t                 state;
  logic [NUM_MASTERS-1:0] grant, nxt_gnt, req;
  logic [LW-1:0]          last, g, idx;
  logic [31:0]            addr_a [NUM_MASTERS];
  logic [31:0]            data_a [NUM_MASTERS];
  logic                   own;
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign addr_a[k] = m_addr_i[32*k +: 32];
    assign data_a[k] = m_data_i[32*k +: 32];
  end
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_MASTERS; i++) g = grant[i] ? LW'(i) : g;
  end
  // Scan downward so the last hit is the first requester above last.
  always_comb begin
    idx     = '0;
    nxt_gnt = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx     = LW'((int'(last) + i) % NUM_MASTERS);
      nxt_gnt = req[idx] ? NUM_MASTERS'(1) << idx : nxt_gnt;
    end
  end
  assign own      = state == OWNED;
  assign s_cyc_o  = own & m_cyc_i[g];
  assign s_stb_o  = own & m_stb_i[g];
  assign s_we_o   = own & m_we_i[g];
  assign s_addr_o = own ? addr_a[g] : '0;
  assign s_data_o = own ? data_a[g] : '0;
  assign m_data_o = s_data_i;
  assign m_gnt_o  = grant;
  assign m_ack_o  = grant & {NUM_MASTERS{s_ack_i}};
`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0]             cnt;
  logic [NUM_MASTERS-1:0] err, blocked;
  logic                   stall;
  // A timed-out master stays masked until it has dropped cyc once.
  assign req     = m_cyc_i & ~blocked;
  assign stall   = own & s_stb_o & ~s_ack_i;
  assign m_err_o = err;
`else
  assign req     = m_cyc_i;
  assign m_err_o = '0;
`endif
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt     <= '0;
      err     <= '0;
      blocked <= '0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err     <= '0;
      blocked <= blocked & m_cyc_i;
      cnt     <= stall ? cnt + 8'd1 : 8'd0;
`endif
      if (!own) begin
        if (|req) begin
          grant <= nxt_gnt;
          state <= OWNED;
        end
      end else if (!m_cyc_i[g]) begin
        grant <= '0;
        last  <= g;
        state <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        cnt   <= '0;
      end else if (stall && cnt == 8'(TIMEOUT_CYCLES - 1)) begin
        grant   <= '0;
        last    <= g;
        state   <= IDLE;
        err     <= grant;
        blocked <= (blocked & m_cyc_i) | grant;
        cnt     <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// tb_wb_gpio_arbiter: scoreboard bench for wb_gpio_arbiter with two masters.
// Covers the WB_ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_wb_gpio_arbiter;
  typedef struct {int m; logic we; logic [31:0] a; logic [31:0] d;} exp_t;
  logic        clk_i = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_addr, m_data;
  logic [31:0] m_data_o, s_addr_o, s_data_o, s_data_i;
  logic [1:0]  m_ack_o, m_err_o, m_gnt_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  wb_gpio_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_addr_i(m_addr), .m_data_i(m_data),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_gnt_o(m_gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input int k, input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    m_cyc[k] = c;
    m_stb[k] = c;
    m_we[k]  = w;
    m_addr[32*k +: 32] = a;
    m_data[32*k +: 32] = d;
  endtask
  task automatic push(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{k, w, a, d});
  endtask
  // Every slave ack outside reset must retire the oldest expected transfer.
  always @(negedge clk_i) begin
    if (!rst && s_ack_i) begin
      if (sb.size() == 0) check("sb_underrun", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("sb_addr", s_addr_o, mon_e.a);
        check("sb_we", s_we_o, mon_e.we);
        if (mon_e.we) check("sb_wdata", s_data_o, mon_e.d);
        else check("sb_rdata", m_data_o, mon_e.d);
        check("sb_ack", m_ack_o, 2'b01 << mon_e.m);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_addr = {32'h44, 32'h33}; m_data = '0; s_data_i = '0; s_ack_i = 1'b1;
    @(negedge clk_i);
    check("rst_scyc", s_cyc_o, 0);
    check("rst_sstb", s_stb_o, 0);
    check("rst_saddr", s_addr_o, 0);
    check("rst_gnt", m_gnt_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    tick; rst = 1'b0; s_ack_i = 1'b0;
    @(negedge clk_i); check("rst_idle", m_gnt_o, 0);
    tick;
    @(negedge clk_i); check("rst_first", m_gnt_o, 2'b01);
    tick; m_cyc = 2'b00; m_stb = 2'b00;
    tick;
    // single write by master 0
    drive(0, 1, 1, 32'h4, 32'hA5A5_0001); push(0, 1, 32'h4, 32'hA5A5_0001);
    @(negedge clk_i); check("wr_idle", s_stb_o, 0);
    tick;
    @(negedge clk_i);
    check("wr_stb", s_stb_o, 1);
    check("wr_addr", s_addr_o, 32'h4);
    check("wr_data", s_data_o, 32'hA5A5_0001);
    check("wr_we", s_we_o, 1);
    check("wr_noack", m_ack_o, 0);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i); check("wr_ack", m_ack_o, 2'b01);
    tick; s_ack_i = 1'b0; drive(0, 0, 0, 0, 0);
    @(negedge clk_i); check("wr_ack_once", m_ack_o, 0);
    tick;
    // read by master 1
    drive(1, 1, 0, 32'h0, 32'h0); s_data_i = 32'hFF; push(1, 0, 32'h0, 32'hFF);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i);
    check("rd_ack", m_ack_o, 2'b10);
    check("rd_data", m_data_o, 32'hFF);
    tick; s_ack_i = 1'b0; drive(1, 0, 0, 0, 0);
    tick;
    // both masters contend; last owner was 1 so 0 goes first
    drive(0, 1, 1, 32'h100, 32'h1111); drive(1, 1, 1, 32'h200, 32'h2222);
    push(0, 1, 32'h100, 32'h1111); push(1, 1, 32'h200, 32'h2222);
    @(negedge clk_i); check("rr_pre", m_gnt_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick; s_ack_i = 1'b1;
      @(negedge clk_i); check("rr_gnt", m_gnt_o, 2'b01 << (i % 2));
      tick; s_ack_i = 1'b0; drive(i % 2, 0, 0, 0, 0);
      tick;
      if (i < 2) begin
        drive(i % 2, 1, 1, 32'h100 * (i % 2 + 1), 32'h1111 * (i % 2 + 1));
        push(i % 2, 1, 32'h100 * (i % 2 + 1), 32'h1111 * (i % 2 + 1));
      end
      @(negedge clk_i); check("rr_idle", m_gnt_o, 0);
    end
    // master 1 held off while master 0 owns
    drive(0, 1, 1, 32'h300, 32'h3333); push(0, 1, 32'h300, 32'h3333);
    tick;
    drive(1, 1, 0, 32'h400, 32'h0); push(1, 0, 32'h400, 32'h1234_5678);
    @(negedge clk_i);
    check("ho_gnt0", m_gnt_o, 2'b01);
    check("ho_addr", s_addr_o, 32'h300);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i); check("ho_noack", m_ack_o[1], 0);
    tick; s_ack_i = 1'b0;
    @(negedge clk_i);
    check("ho_addr2", s_addr_o, 32'h300);
    check("ho_ack2", m_ack_o, 0);
    tick; drive(0, 0, 0, 0, 0);
    @(negedge clk_i); check("ho_hold", m_gnt_o, 2'b01);
    tick;
    @(negedge clk_i); check("ho_idle", m_gnt_o, 0);
    tick; s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
    @(negedge clk_i); check("ho_gnt1", m_gnt_o, 2'b10);
    tick; s_ack_i = 1'b0; drive(1, 0, 0, 0, 0);
    tick;
    // owner drops cyc in its ack cycle
    drive(0, 1, 1, 32'h500, 32'h5555); push(0, 1, 32'h500, 32'h5555);
    tick; s_ack_i = 1'b1; m_cyc[0] = 1'b0;
    @(negedge clk_i);
    check("dropack_ack", m_ack_o, 2'b01);
    check("dropack_cyc", s_cyc_o, 0);
    tick; s_ack_i = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk_i); check("drop_rel", m_gnt_o, 0);
    // owner abandons transfer without ack
    drive(0, 1, 0, 32'h600, 32'h0);
    tick;
    @(negedge clk_i); check("ab_stb", s_stb_o, 1);
    tick; drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("ab_stb_fall", s_stb_o, 0);
    check("ab_ack", m_ack_o, 0);
    tick;
    @(negedge clk_i); check("ab_idle", m_gnt_o, 0);
    // asynchronous reset mid-transfer, then round-robin restarts at master 0
    drive(1, 1, 1, 32'h700, 32'h7777);
    tick;
    @(negedge clk_i); check("ms_stb", s_stb_o, 1);
    #2 rst = 1'b1;
    #1;
    check("ms_rst_stb", s_stb_o, 0);
    check("ms_rst_gnt", m_gnt_o, 0);
    drive(1, 0, 0, 0, 0);
    tick; rst = 1'b0;
    drive(0, 1, 1, 32'h800, 32'h8888); drive(1, 1, 1, 32'h900, 32'h9999);
    push(0, 1, 32'h800, 32'h8888);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i); check("ms_rr", m_gnt_o, 2'b01);
    tick; s_ack_i = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    tick;
`ifdef WB_ARB_TIMEOUT_EN
    drive(0, 1, 1, 32'hA00, 32'hAAAA);
    tick;
    drive(1, 1, 1, 32'hB00, 32'hBBBB); push(1, 1, 32'hB00, 32'hBBBB);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i); check("to_stall", {m_err_o, m_gnt_o}, {2'b00, 2'b01});
      tick;
    end
    @(negedge clk_i);
    check("to_err", m_err_o, 2'b01);
    check("to_gnt", m_gnt_o, 0);
    check("to_cyc", s_cyc_o, 0);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i);
    check("to_err_once", m_err_o, 0);
    check("to_m1", m_gnt_o, 2'b10);
    tick; s_ack_i = 1'b0; drive(1, 0, 0, 0, 0);
    tick;
    @(negedge clk_i); check("to_block0", m_gnt_o, 0);
    tick;
    @(negedge clk_i); check("to_block1", m_gnt_o, 0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick;
    drive(0, 1, 1, 32'hC00, 32'hCCCC); push(0, 1, 32'hC00, 32'hCCCC);
    tick; s_ack_i = 1'b1;
    @(negedge clk_i); check("to_regrant", m_gnt_o, 2'b01);
    tick; s_ack_i = 1'b0; drive(0, 0, 0, 0, 0);
    tick;
`endif
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
